// File: rtl/tanh_pkg.sv
// Shared types and constants for the tanh input sequencer and its FIFO.
package tanh_pkg;

   localparam int DEPTH_DEFAULT   = 4;
   localparam int TIMEOUT_DEFAULT = 64;

   localparam logic [15:0] ONE_Q15  = 16'h7FFF;
   localparam logic [15:0] ZERO_Q15 = 16'h0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } seq_state_e;

   // |x| in Q1.15; -1.0 has no positive counterpart, so it clamps to just under 1.0.
   function automatic logic [15:0] satMagnitude(input logic [15:0] x);
      if (x == 16'h8000) begin
         return ONE_Q15;
      end else if (x[15]) begin
         return ~x + 16'd1;
      end else begin
         return x;
      end
   endfunction

endpackage

// File: rtl/tanh_fifo.sv
// Small synchronous FIFO buffering input samples; DEPTH must be a power of two (>= 2).
module tanh_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             data_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic doPush, doPop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rdPtr_q];
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      if (doPush && !doPop) count_d = count_q + CNT_W'(1);
      else if (doPop && !doPush) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= data_i;
   end

endmodule

// File: rtl/tanh_input_sequencer.sv
// Feeds signed Q1.15 samples through an unsigned tanh core: buffers input, issues |x|,
// restores the sign on the result, and reports an error if the core never answers.
module tanh_input_sequencer
   import tanh_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   output logic        in_ready,
   output logic        core_start,
   output logic [15:0] core_x,
   input  logic        core_done,
   input  logic [15:0] core_y,
   output logic        out_valid,
   output logic [15:0] out_data,
   output logic        out_err,
   input  logic        out_ready
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   seq_state_e       state_q, state_d;
   logic             readyEn_q;
   logic             fifoPush, fifoPop, fifoFull, fifoEmpty;
   logic [15:0]      fifoHead;
   logic [CNT_W-1:0] unusedCount;
   logic             sign_q, sign_d;
   logic [15:0]      mag_q, mag_d;
   logic [15:0]      outData_q, outData_d;
   logic             outErr_q, outErr_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             timerExpired;

   // Holds in_ready low through reset and releases it on the first clock afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) readyEn_q <= 1'b0;
      else        readyEn_q <= 1'b1;
   end

   assign in_ready = readyEn_q && !fifoFull;
   assign fifoPush = in_valid && in_ready;

   tanh_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifoPush),
      .data_i  (in_data),
      .pop_i   (fifoPop),
      .data_o  (fifoHead),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .count_o (unusedCount)
   );

   assign timerExpired = (state_q == WAIT) && (timer_q == TMR_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!fifoEmpty) state_d = (fifoHead == ZERO_Q15) ? OUT : ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (core_done || timerExpired) state_d = OUT;
         OUT:     if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fifoPop    = 1'b0;
      core_start = 1'b0;
      out_valid  = 1'b0;
      case (state_q)
         IDLE:    fifoPop = !fifoEmpty;
         ISSUE:   core_start = 1'b1;
         OUT:     out_valid = 1'b1;
         default: ;
      endcase
   end

   // A zero sample skips the core, so its (zero) result is staged at pop time.
   always_comb begin
      sign_d    = sign_q;
      mag_d     = mag_q;
      outData_d = outData_q;
      outErr_d  = outErr_q;
      timer_d   = '0;
      if (fifoPop) begin
         sign_d    = fifoHead[15];
         mag_d     = satMagnitude(fifoHead);
         outData_d = ZERO_Q15;
         outErr_d  = 1'b0;
      end
      if (state_q == WAIT) begin
         if (core_done) begin
            outData_d = sign_q ? (~core_y + 16'd1) : core_y;
            outErr_d  = 1'b0;
         end else if (timerExpired) begin
            outData_d = ZERO_Q15;
            outErr_d  = 1'b1;
         end else begin
            timer_d = timer_q + TMR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_q    <= 1'b0;
         mag_q     <= ZERO_Q15;
         outData_q <= ZERO_Q15;
         outErr_q  <= 1'b0;
         timer_q   <= '0;
      end else begin
         sign_q    <= sign_d;
         mag_q     <= mag_d;
         outData_q <= outData_d;
         outErr_q  <= outErr_d;
         timer_q   <= timer_d;
      end
   end

   assign core_x   = mag_q;
   assign out_data = outData_q;
   assign out_err  = outErr_q;

endmodule

// File: tb/tb_tanh_input_sequencer.sv
// Self-checking bench for tanh_input_sequencer: directed and random samples against a
// queue-based reference, with a behavioural stand-in for the tanh core.
module tb_tanh_input_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = 16'h0000;
   logic        in_ready;
   logic        core_start;
   logic [15:0] core_x;
   logic        core_done = 1'b0;
   logic [15:0] core_y = 16'h0000;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_err;
   logic        out_ready = 1'b0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [15:0] expQ[$];
   logic [15:0] magQ[$];
   int expStarts = 0;
   int startCount = 0;
   int outValidCycles = 0;
   int acceptCyc = 0;
   int startCyc = 0;
   int doneCyc = 0;
   int outRiseCyc = 0;
   int baseValid = 0;

   bit          coreNeverDone = 1'b0;
   bit          coreFixedY = 1'b1;
   logic [15:0] fixedY = 16'h1F59;
   int          coreDelay = 20;

   logic [15:0] heldData = 16'h0000;
   logic        heldErr = 1'b0;
   logic        prevStart = 1'b0;
   logic        prevOutValid = 1'b0;
   logic        prevReady = 1'b0;
   logic [16:0] expV;

   tanh_input_sequencer #(
      .DEPTH   (4),
      .TIMEOUT (64)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .core_start (core_start),
      .core_x     (core_x),
      .core_done  (core_done),
      .core_y     (core_y),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_err    (out_err),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: magnitude of a signed Q1.15 value, clamped to the largest positive code.
   function automatic logic [15:0] refMag(input logic [15:0] x);
      int v = int'($signed(x));
      if (v < 0) v = -v;
      if (v > 32767) v = 32767;
      return 16'(v);
   endfunction

   // Stand-in tanh core transfer: any fixed function of the magnitude will do.
   function automatic logic [15:0] refCore(input logic [15:0] mag);
      if (coreFixedY) return fixedY;
      return 16'((int'(mag) * 3) / 4 + 17);
   endfunction

   // Expected {err, data} for one accepted sample under the current core behaviour.
   function automatic logic [16:0] refResult(input logic [15:0] x);
      int v = int'($signed(x));
      int y;
      if (x == 16'h0000) return 17'd0;
      if (coreNeverDone) return {1'b1, 16'h0000};
      y = int'(refCore(refMag(x)));
      if (v < 0) y = -y;
      return {1'b0, 16'(y)};
   endfunction

   function automatic logic [15:0] randSample();
      int r = int'($urandom_range(0, 7));
      if (r == 0) return 16'h0000;
      if (r == 1) return 16'h8000;
      return 16'($urandom);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Offer one sample from a falling edge; returns on the falling edge after it is taken.
   task automatic applyStimulus(input logic [15:0] x);
      int waitCnt = 0;
      in_data  = x;
      in_valid = 1'b1;
      while (!in_ready && waitCnt < 500) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!in_ready) begin
         checkOutput("accept_wait", in_ready, 1);
         in_valid = 1'b0;
         return;
      end
      acceptCyc = cyc;
      expQ.push_back(x);
      if (x != 16'h0000) begin
         magQ.push_back(refMag(x));
         expStarts++;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int n = 0;
      while (expQ.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checkOutput("drain", expQ.size(), 0);
   endtask

   task automatic checkResetValues();
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_core_start", core_start, 0);
      checkOutput("rst_core_x", core_x, 16'h0000);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_data", out_data, 16'h0000);
      checkOutput("rst_out_err", out_err, 0);
   endtask

   // Core stand-in: answers each start after a delay unless told to stay silent.
   initial begin : coreModel
      logic [15:0] magSeen;
      int d;
      forever begin
         @(negedge clk);
         if (rst_n && core_start && !coreNeverDone) begin
            magSeen = core_x;
            d = (coreDelay > 0) ? coreDelay : int'($urandom_range(1, 10));
            repeat (d) @(negedge clk);
            checkOutput("core_x_hold", core_x, magSeen);
            core_y    = refCore(magSeen);
            core_done = 1'b1;
            doneCyc   = cyc;
            @(negedge clk);
            core_done = 1'b0;
            core_y    = 16'($urandom);
         end
      end
   end

   // Monitor samples just after the falling edge so bench drives at that edge are settled.
   always begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
         prevStart    = 1'b0;
         prevOutValid = 1'b0;
         prevReady    = 1'b0;
      end else begin
         if (core_start) begin
            checkOutput("start_pulse", prevStart, 0);
            startCount++;
            startCyc = cyc;
            if (magQ.size() > 0) checkOutput("core_x", core_x, magQ.pop_front());
            else checkOutput("start_unexpected", startCount, expStarts);
         end
         if (out_valid) begin
            outValidCycles++;
            if (!prevOutValid) outRiseCyc = cyc;
            else if (!prevReady) begin
               checkOutput("out_data_stable", out_data, heldData);
               checkOutput("out_err_stable", out_err, heldErr);
            end
            heldData = out_data;
            heldErr  = out_err;
            if (out_ready) begin
               if (expQ.size() > 0) begin
                  expV = refResult(expQ.pop_front());
                  checkOutput("out_data", out_data, expV[15:0]);
                  checkOutput("out_err", out_err, expV[16]);
               end else begin
                  checkOutput("out_unexpected", out_valid, 0);
               end
            end
         end
         prevStart    = core_start;
         prevOutValid = out_valid;
         prevReady    = out_ready;
      end
   end

   initial begin
      // Reset values, then in_ready release on the first clock.
      repeat (2) @(negedge clk);
      #1;
      checkResetValues();
      rst_n = 1'b1;
      #1;
      checkOutput("ready_before_clk", in_ready, 0);
      @(negedge clk);
      checkOutput("ready_after_reset", in_ready, 1);

      // Positive, negative and -1.0 samples with a slow fixed-answer core.
      out_ready  = 1'b1;
      coreFixedY = 1'b1;
      fixedY     = 16'h1F59;
      coreDelay  = 20;
      applyStimulus(16'h2000);
      waitDrain();
      checkOutput("start_latency", startCyc, acceptCyc + 2);
      checkOutput("done_to_valid", outRiseCyc, doneCyc + 1);
      applyStimulus(16'hE000);
      waitDrain();
      applyStimulus(16'h8000);
      waitDrain();
      checkOutput("start_count_a", startCount, expStarts);

      // Zero bypasses the core.
      applyStimulus(16'h0000);
      waitDrain();
      checkOutput("zero_latency", outRiseCyc, acceptCyc + 2);
      checkOutput("zero_no_start", startCount, expStarts);

      // A done pulse while idle must have no effect.
      baseValid = outValidCycles;
      core_y    = 16'h4321;
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("spurious_done_valid", outValidCycles, baseValid);
      checkOutput("spurious_done_start", startCount, expStarts);

      // Backpressure: five samples fill the FIFO plus one in flight.
      out_ready  = 1'b0;
      coreFixedY = 1'b0;
      coreDelay  = 0;
      for (int i = 0; i < 5; i++) applyStimulus(randSample());
      checkOutput("full_ready", in_ready, 0);
      in_data  = 16'h1111;
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("full_hold_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      waitDrain();

      // Random traffic with random downstream stalls.
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               applyStimulus(randSample());
            end
         end
         begin
            repeat (200) begin
               @(negedge clk);
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      waitDrain();
      checkOutput("start_count_b", startCount, expStarts);

      // Silent core: timeout after 64 wait cycles, then normal operation resumes.
      coreNeverDone = 1'b1;
      applyStimulus(16'h3000);
      waitDrain();
      checkOutput("timeout_latency", outRiseCyc - startCyc, 65);
      coreNeverDone = 1'b0;
      coreFixedY    = 1'b1;
      coreDelay     = 20;
      applyStimulus(16'hE000);
      waitDrain();

      // Reset while waiting on the core with three samples queued.
      coreNeverDone = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(16'($urandom) | 16'h0001);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkResetValues();
      expQ.delete();
      magQ.delete();
      expStarts = startCount;
      baseValid = outValidCycles;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      checkOutput("no_out_after_reset", outValidCycles, baseValid);
      checkOutput("no_start_after_reset", startCount, expStarts);
      coreNeverDone = 1'b0;
      applyStimulus(16'h2000);
      waitDrain();
      checkOutput("start_count_c", startCount, expStarts);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
